// File: rtl/apb_cfg_master.sv
// apb_cfg_master: FIFO-buffered command queue driving an APB requester, one response pulse per transfer
// Ports: clk/resetn (async active-low); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata command push;
//        PADDR/PWRITE/PSEL/PENABLE/PWDATA requester outputs, PRDATA/PREADY completer inputs;
//        rsp_valid/rsp_write/rsp_rdata/rsp_err completion report; busy = queue or bus active.
// Option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_cfg_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [7:0]  PADDR,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("apb_cfg_master: FIFO_DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES >= 1");
  end
  state_t        r_state, w_nstate;
  logic [40:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_rdy;
  logic [7:0]    r_paddr;
  logic          r_pwrite;
  logic [31:0]   r_pwdata;
  logic          r_rsp_valid, r_rsp_write;
  logic [31:0]   r_rsp_rdata;
  logic          w_empty, w_push, w_pop, w_done, w_fin, w_err;
  // cmd_ready comes from the registered count only, so a pop cannot make room for a push in the same cycle
  assign w_empty   = r_cnt == '0;
  assign cmd_ready = r_rdy && r_cnt != (AW+1)'(FIFO_DEPTH);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_fin     = r_state == ACCESS && w_done;
  assign PSEL      = r_state != IDLE;
  assign PENABLE   = r_state == ACCESS;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = !w_empty || r_state != IDLE;
`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  logic          r_rsp_err, w_tmo;
  // r_tmo is the index of the current ACCESS cycle; the last allowed one aborts
  assign w_tmo   = r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign w_done  = PREADY || w_tmo;
  assign w_err   = w_tmo && !PREADY;
  assign rsp_err = r_rsp_err;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tmo     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_tmo <= (r_state == ACCESS && !w_done) ? r_tmo + 1'b1 : '0;
      if (w_fin) r_rsp_err <= w_err;
    end
  end
`else
  assign w_done  = PREADY;
  assign w_err   = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    w_pop    = !w_empty && (r_state == IDLE || w_fin);
    w_nstate = (r_state == SETUP) ? ACCESS :
               (r_state == ACCESS && !w_done) ? ACCESS :
               w_empty ? IDLE : SETUP;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nstate;
  end
  // read entries carry zero write data so PWDATA is 0 during reads without extra muxing
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {cmd_write, cmd_addr, cmd_write ? cmd_wdata : 32'h0};
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_pop) begin
      {r_pwrite, r_paddr, r_pwdata} <= r_mem[r_rp];
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_fin;
      if (w_fin) begin
        r_rsp_write <= r_pwrite;
        r_rsp_rdata <= (r_pwrite || w_err) ? 32'h0 : PRDATA;
      end
    end
  end
endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: directed self-checking bench for apb_cfg_master
module tb_apb_cfg_master;
  logic        clk = 1'b0;
  logic        resetn, cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, PADDR;
  logic [31:0] cmd_wdata, PWDATA, PRDATA, rsp_rdata, prdata_r;
  logic        PWRITE, PSEL, PENABLE, PREADY, rsp_valid, rsp_write, rsp_err, busy;
  logic        use_model;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  assign PRDATA = use_model ? {24'hA5A5A5, PADDR} : prdata_r;
  apb_cfg_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );
  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_write, rsp_err, busy, cmd_ready} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_write, rsp_err, busy, cmd_ready});
    end
    total++;
    if ({PADDR, PWDATA, rsp_rdata} !== 72'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {PADDR, PWDATA, rsp_rdata});
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_early got=%b exp=0", cmd_ready);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_rise got=%b exp=1", cmd_ready);
    end
  endtask
  task automatic test_write;
    logic [2:0] exp;
    PREADY = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      exp = (c == 2) ? 3'b100 : (c == 3) ? 3'b110 : (c == 4) ? 3'b001 : 3'b000;
      total++;
      if ({PSEL, PENABLE, rsp_valid} !== exp) begin
        bad++;
        $display("FAIL wr_ctl c=%0d got=%b exp=%b", c, {PSEL, PENABLE, rsp_valid}, exp);
      end
      if (c >= 2 && c <= 4) begin
        total++;
        if ({PADDR, PWRITE, PWDATA} !== {8'h04, 1'b1, 32'hDEADBEEF}) begin
          bad++;
          $display("FAIL wr_bus c=%0d got=%h/%b/%h exp=04/1/deadbeef", c, PADDR, PWRITE, PWDATA);
        end
      end
      if (c == 4) begin
        total++;
        if ({rsp_write, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
          bad++;
          $display("FAIL wr_rsp got=%b/%h/%b exp=1/00000000/0", rsp_write, rsp_rdata, rsp_err);
        end
      end
      if (c == 1 || c == 5) begin
        total++;
        if (busy !== (c == 1)) begin
          bad++;
          $display("FAIL wr_busy c=%0d got=%b exp=%b", c, busy, c == 1);
        end
      end
    end
  endtask
  task automatic test_read_wait;
    logic [2:0] exp;
    PREADY = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 32'hFFFF0000;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      PREADY = (c == 6);
      prdata_r = (c == 6) ? 32'h12345678 : 32'hFFFFFFFF;
      @(negedge clk);
      exp = (c == 2) ? 3'b100 : (c >= 3 && c <= 6) ? 3'b110 : (c == 7) ? 3'b001 : 3'b000;
      total++;
      if ({PSEL, PENABLE, rsp_valid} !== exp) begin
        bad++;
        $display("FAIL rd_ctl c=%0d got=%b exp=%b", c, {PSEL, PENABLE, rsp_valid}, exp);
      end
      if (c >= 2 && c <= 6) begin
        total++;
        if ({PADDR, PWRITE, PWDATA} !== {8'h10, 1'b0, 32'h0}) begin
          bad++;
          $display("FAIL rd_bus c=%0d got=%h/%b/%h exp=10/0/00000000", c, PADDR, PWRITE, PWDATA);
        end
      end
      if (c >= 7) begin
        total++;
        if ({rsp_write, rsp_rdata, rsp_err} !== {1'b0, 32'h12345678, 1'b0}) begin
          bad++;
          $display("FAIL rd_rsp c=%0d got=%b/%h/%b exp=0/12345678/0", c, rsp_write, rsp_rdata, rsp_err);
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    int k_iss, k_rsp;
    logic        ew;
    logic [7:0]  ea;
    logic [31:0] ed, er;
    PREADY = 1'b0; use_model = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = (k % 2 == 0); cmd_addr = 8'h20 + 8'(k); cmd_wdata = 32'h1000_0000 + 32'(k);
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready k=%0d got=%b exp=1", k, cmd_ready);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      cmd_write = 1'b1; cmd_addr = 8'h99; cmd_wdata = 32'h99;
      @(negedge clk);
      total++;
      if ({cmd_ready, busy} !== 2'b01) begin
        bad++;
        $display("FAIL b2b_full c=%0d got=%b exp=01", c, {cmd_ready, busy});
      end
    end
    k_iss = 0; k_rsp = 0;
    for (int c = 0; c < 40 && k_rsp < 5; c++) begin
      @(posedge clk); #1;
      PREADY = 1'b1;
      if (c == 1) cmd_valid = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (cmd_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_full_pop got=%b exp=0", cmd_ready);
        end
      end
      if (k_iss < 5) begin
        total++;
        if (PSEL !== 1'b1) begin
          bad++;
          $display("FAIL b2b_psel c=%0d got=%b exp=1", c, PSEL);
        end
      end
      if (PSEL && PENABLE) begin
        ew = (k_iss % 2 == 0); ea = 8'h20 + 8'(k_iss); ed = ew ? 32'h1000_0000 + 32'(k_iss) : 32'h0;
        total++;
        if ({PWRITE, PADDR, PWDATA} !== {ew, ea, ed}) begin
          bad++;
          $display("FAIL b2b_bus k=%0d got=%b/%h/%h exp=%b/%h/%h", k_iss, PWRITE, PADDR, PWDATA, ew, ea, ed);
        end
        k_iss++;
      end
      if (rsp_valid) begin
        ew = (k_rsp % 2 == 0); er = ew ? 32'h0 : {24'hA5A5A5, 8'h20 + 8'(k_rsp)};
        total++;
        if ({rsp_write, rsp_rdata} !== {ew, er}) begin
          bad++;
          $display("FAIL b2b_rsp k=%0d got=%b/%h exp=%b/%h", k_rsp, rsp_write, rsp_rdata, ew, er);
        end
        k_rsp++;
      end
    end
    total++;
    if (k_rsp != 5) begin
      bad++;
      $display("FAIL b2b_timeout got=%0d exp=5", k_rsp);
    end
    @(negedge clk);
    total++;
    if ({busy, rsp_valid, PSEL} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_drain got=%b exp=000", {busy, rsp_valid, PSEL});
    end
    use_model = 1'b0;
  endtask
  task automatic test_reset_mid;
    PREADY = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_addr = 8'h45;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({PSEL, PENABLE, PADDR} !== {2'b11, 8'h44}) begin
      bad++;
      $display("FAIL rstmid_access got=%b/%h exp=11/44", {PSEL, PENABLE}, PADDR);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({PSEL, PENABLE, busy, cmd_ready, rsp_valid} !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_async got=%b exp=00000", {PSEL, PENABLE, busy, cmd_ready, rsp_valid});
    end
    @(posedge clk); #1 PREADY = 1'b1;
    @(posedge clk); #1 resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({PSEL, rsp_valid, busy} !== 3'b000) begin
        bad++;
        $display("FAIL rstmid_quiet c=%0d got=%b exp=000", c, {PSEL, rsp_valid, busy});
      end
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got=%b exp=1", cmd_ready);
    end
  endtask
`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    PREADY = 1'b0; prdata_r = 32'hFFFFFFFF;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      cmd_valid = (c == 1); cmd_write = 1'b1; cmd_addr = 8'h51; cmd_wdata = 32'hCAFE0001;
      PREADY = (c == 12);
      @(negedge clk);
      if (c >= 10) begin
        total++;
        if (rsp_valid !== (c == 11 || c == 13)) begin
          bad++;
          $display("FAIL tmo_valid c=%0d got=%b exp=%b", c, rsp_valid, c == 11 || c == 13);
        end
      end
      if (c == 11 || c == 13) begin
        total++;
        if ({rsp_write, rsp_rdata, rsp_err} !== {c == 13, 32'h0, c == 11}) begin
          bad++;
          $display("FAIL tmo_rsp c=%0d got=%b/%h/%b exp=%b/00000000/%b", c, rsp_write, rsp_rdata, rsp_err, c == 13, c == 11);
        end
      end
      if (c == 11) begin
        total++;
        if ({PSEL, PENABLE, PADDR} !== {2'b10, 8'h51}) begin
          bad++;
          $display("FAIL tmo_next got=%b/%h exp=10/51", {PSEL, PENABLE}, PADDR);
        end
      end
    end
  endtask
`endif
  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; prdata_r = 32'hFFFFFFFF; use_model = 1'b0;
    test_reset;
    test_write;
    test_read_wait;
    test_back_to_back;
    test_reset_mid;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
